cv32e40n_apu_requester: RTL and testbench
=========================================

# cv32e40n_apu_requester

Core-side initiator for the APU request/response channel. Accepts one command at a time from the core over a valid/ready port, then drives the APU request channel (`apu_req`/`apu_gnt`) until the request is granted. It waits for the response channel (`apu_rvalid`), with an optional timeout, and presents the captured result to the core writeback over a second valid/ready port. It sits between the core ID/EX stage and any APU responder, including the dummy accelerator.

## Interface
Parameters:
- `NARGS`, default `APU_NARGS_CPU`: number of 32-bit operands.
- `WOP`, default `APU_WOP_CPU`: opcode width.
- `NDSFLAGS`, default `APU_NDSFLAGS_CPU`: downstream flag width.
- `NUSFLAGS`, default `APU_NUSFLAGS_CPU`: upstream flag width.
- `TIMEOUT_CYCLES`, default 64: maximum number of WAIT cycles. 0 disables the timeout.

Ports:
- `clk_i`  in  1  clock. All logic is on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `cmd_valid_i`  in  1  command offered.
- `cmd_ready_o`  out  1  command accepted when both `cmd_valid_i` and `cmd_ready_o` are high.
- `cmd_operands_i`  in  NARGS×32  operands.
- `cmd_op_i`  in  WOP  opcode.
- `cmd_flags_i`  in  NDSFLAGS  downstream flags.
- `cmd_rd_i`  in  5  destination register tag.
- `apu_req_o`  out  1  request valid.
- `apu_gnt_i`  in  1  request granted.
- `apu_operands_o`  out  NARGS×32  registered operands.
- `apu_op_o`  out  WOP  registered opcode.
- `apu_flags_o`  out  NDSFLAGS  registered downstream flags.
- `apu_rvalid_i`  in  1  response valid.
- `apu_result_i`  in  32  response result.
- `apu_flags_i`  in  NUSFLAGS  response flags.
- `wb_valid_o`  out  1  writeback data available.
- `wb_ready_i`  in  1  writeback consumed.
- `wb_result_o`  out  32  captured result.
- `wb_flags_o`  out  NUSFLAGS  captured flags.
- `wb_rd_o`  out  5  tag of the command that produced this result.
- `wb_err_o`  out  1  result was produced by a timeout, not a response.
- `busy_o`  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT, WB. All handshake outputs are decoded combinationally from the state.
- **IDLE**
  - `cmd_ready_o=1`.
  - On `cmd_valid_i`: latch operands, op, flags and rd into command registers; go to REQ.
- **REQ**
  - `apu_req_o=1`. `apu_operands_o`/`apu_op_o`/`apu_flags_o` come from the command registers and are held stable until grant.
  - `apu_gnt_i=1` completes the request in that same cycle: clear the timer, go to WAIT.
  - Otherwise stay in REQ, with no limit on how long.
- **WAIT**
  - `apu_req_o=0`. The timer increments each cycle; its width is `$clog2(TIMEOUT_CYCLES+1)`, minimum 1.
  - `apu_rvalid_i=1`: capture `apu_result_i` and `apu_flags_i`, set err=0, go to WB.
  - Else, if `TIMEOUT_CYCLES≠0` and timer == `TIMEOUT_CYCLES-1`: result=0, flags=0, err=1, go to WB.
  - If `apu_rvalid_i` and the timeout hit coincide, the response wins (err=0).
- **WB**
  - `wb_valid_o=1`. Result, flags, rd and err are held stable until `wb_ready_i`.
  - On `wb_ready_i`: go to IDLE.
- `apu_rvalid_i` in IDLE, REQ or WB is ignored. It must not corrupt the captured result.
- `apu_gnt_i` outside REQ is ignored.
- `busy_o` = (state ≠ IDLE).
- Only one command is outstanding at a time. A new command cannot be accepted in the same cycle that WB retires.

## Timing
- Reset (`rst_i` high at a clock edge):
  - state goes to IDLE, timer to 0.
  - All command and result registers go to 0, and err to 0.
- While `rst_i` is high, every output reads 0, including `cmd_ready_o`. In the first cycle after `rst_i` deasserts, `cmd_ready_o=1`.
- Reset mid-operation abandons the transaction with no writeback. A response arriving after reset is ignored.
- Best-case latency with a granting responder and `apu_rvalid_i` in the first WAIT cycle:
  - cycle 0: command accepted;
  - cycle 1: REQ with grant;
  - cycle 2: WAIT, rvalid arrives;
  - cycle 3: `wb_valid_o` high.
- With `wb_ready_i` held high, the next command is accepted at cycle 4. Peak throughput is one command per 4 cycles.
- With the dummy responder: grant in cycle 1 and rvalid in cycle 2 give `wb_valid_o` in cycle 3.

## Test plan
- **Single operation:** op=1, operands {0x11, 0x22, 0x33}, rd=7; responder grants immediately and returns rvalid with result 0xDEAD_BEEF one cycle later.
  - `apu_req_o` is high in cycle 1 only.
  - `wb_valid_o` rises in cycle 3 with result 0xDEADBEEF, rd=7, err=0.
- **Grant stall:** hold `apu_gnt_i` low for 5 cycles.
  - `apu_req_o` stays high for 6 cycles with operands unchanged.
  - `cmd_ready_o` stays 0 for that whole period.
- **Timeout:** `TIMEOUT_CYCLES=4`, responder never asserts `apu_rvalid_i`.
  - `wb_valid_o` rises after exactly 4 WAIT cycles with result 0 and err=1.
  - A separate run with rvalid arriving exactly on the 4th WAIT cycle gives err=0 and the real result.
- **Writeback backpressure:** hold `wb_ready_i` low for 3 cycles while `apu_rvalid_i` pulses spuriously with result 0x1234.
  - Writeback outputs stay stable; the spurious result is not captured.
  - Retire occurs on the first `wb_ready_i`.
- **Reset mid-WAIT:** assert `rst_i` for 1 cycle during WAIT, then send rvalid.
  - All outputs are 0 during reset.
  - The late rvalid is ignored and no writeback occurs.
  - The next command completes normally.
- **Back-to-back:** 10 commands with `wb_ready_i`=1 and the dummy responder.
  - Completions are in order with tags preserved.
  - Each command is accepted exactly 4 cycles after the previous one.

Source files
------------

// File: rtl/cv32e40n_apu_requester.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40n_apu_requester
// Brief    : Core-side APU initiator: command in, APU request/response, writeback out.
// Revision : 1.0
// ============================================================================
module cv32e40n_apu_requester #(
    parameter int unsigned NARGS          = 3,
    parameter int unsigned WOP            = 6,
    parameter int unsigned NDSFLAGS       = 15,
    parameter int unsigned NUSFLAGS       = 5,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [NARGS*32-1:0]   cmd_operands_i,
    input  logic [WOP-1:0]        cmd_op_i,
    input  logic [NDSFLAGS-1:0]   cmd_flags_i,
    input  logic [4:0]            cmd_rd_i,
    output logic                  apu_req_o,
    input  logic                  apu_gnt_i,
    output logic [NARGS*32-1:0]   apu_operands_o,
    output logic [WOP-1:0]        apu_op_o,
    output logic [NDSFLAGS-1:0]   apu_flags_o,
    input  logic                  apu_rvalid_i,
    input  logic [31:0]           apu_result_i,
    input  logic [NUSFLAGS-1:0]   apu_flags_i,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [31:0]           wb_result_o,
    output logic [NUSFLAGS-1:0]   wb_flags_o,
    output logic [4:0]            wb_rd_o,
    output logic                  wb_err_o,
    output logic                  busy_o
);

    localparam int unsigned C_TIMER_W      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned C_TIMER_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [C_TIMER_W-1:0] C_TIMER_LAST = C_TIMER_LAST_I[C_TIMER_W-1:0];
    localparam bit   C_TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_WB   = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [NARGS*32-1:0]    operands_q, operands_d;
    logic [WOP-1:0]         op_q, op_d;
    logic [NDSFLAGS-1:0]    dflags_q, dflags_d;
    logic [4:0]             rd_q, rd_d;
    logic [31:0]            result_q, result_d;
    logic [NUSFLAGS-1:0]    uflags_q, uflags_d;
    logic                   err_q, err_d;
    logic [C_TIMER_W-1:0]   timer_q, timer_d;
    logic                   w_run;

    always_comb begin
        state_d    = state_q;
        operands_d = operands_q;
        op_d       = op_q;
        dflags_d   = dflags_q;
        rd_d       = rd_q;
        result_d   = result_q;
        uflags_d   = uflags_q;
        err_d      = err_q;
        timer_d    = timer_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    operands_d = cmd_operands_i;
                    op_d       = cmd_op_i;
                    dflags_d   = cmd_flags_i;
                    rd_d       = cmd_rd_i;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (apu_gnt_i) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + C_TIMER_W'(1);
                // A response in the timeout cycle still counts as a real result.
                if (apu_rvalid_i) begin
                    result_d = apu_result_i;
                    uflags_d = apu_flags_i;
                    err_d    = 1'b0;
                    state_d  = S_WB;
                end else if (C_TIMEOUT_EN && (timer_q == C_TIMER_LAST)) begin
                    result_d = '0;
                    uflags_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_WB;
                end
            end
            S_WB: begin
                if (wb_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            operands_q <= '0;
            op_q       <= '0;
            dflags_q   <= '0;
            rd_q       <= '0;
            result_q   <= '0;
            uflags_q   <= '0;
            err_q      <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            operands_q <= operands_d;
            op_q       <= op_d;
            dflags_q   <= dflags_d;
            rd_q       <= rd_d;
            result_q   <= result_d;
            uflags_q   <= uflags_d;
            err_q      <= err_d;
            timer_q    <= timer_d;
        end
    end

    // Outputs are forced low while reset is asserted, before the registers clear.
    assign w_run          = ~rst_i;
    assign cmd_ready_o    = w_run & (state_q == S_IDLE);
    assign apu_req_o      = w_run & (state_q == S_REQ);
    assign wb_valid_o     = w_run & (state_q == S_WB);
    assign busy_o         = w_run & (state_q != S_IDLE);
    assign apu_operands_o = w_run ? operands_q : '0;
    assign apu_op_o       = w_run ? op_q       : '0;
    assign apu_flags_o    = w_run ? dflags_q   : '0;
    assign wb_result_o    = w_run ? result_q   : '0;
    assign wb_flags_o     = w_run ? uflags_q   : '0;
    assign wb_rd_o        = w_run ? rd_q       : '0;
    assign wb_err_o       = w_run & err_q;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40n_apu_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40n_apu_requester
// Brief    : Vector table plus hand sequences with a writeback scoreboard.
// Revision : 1.0
// ============================================================================
module tb_cv32e40n_apu_requester;
    localparam int NARGS = 3;
    localparam int WOP   = 6;
    localparam int NDS   = 15;
    localparam int NUS   = 5;
    localparam int TO    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                cmd_valid, cmd_ready;
    logic [NARGS*32-1:0] cmd_operands;
    logic [WOP-1:0]      cmd_op;
    logic [NDS-1:0]      cmd_flags;
    logic [4:0]          cmd_rd;
    logic                apu_req, apu_gnt;
    logic [NARGS*32-1:0] apu_operands;
    logic [WOP-1:0]      apu_op;
    logic [NDS-1:0]      apu_dflags;
    logic                apu_rvalid;
    logic [31:0]         apu_result;
    logic [NUS-1:0]      apu_uflags;
    logic                wb_valid, wb_ready;
    logic [31:0]         wb_result;
    logic [NUS-1:0]      wb_flags;
    logic [4:0]          wb_rd;
    logic                wb_err, busy;

    cv32e40n_apu_requester #(
        .NARGS(NARGS), .WOP(WOP), .NDSFLAGS(NDS), .NUSFLAGS(NUS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_operands_i(cmd_operands), .cmd_op_i(cmd_op),
        .cmd_flags_i(cmd_flags), .cmd_rd_i(cmd_rd),
        .apu_req_o(apu_req), .apu_gnt_i(apu_gnt),
        .apu_operands_o(apu_operands), .apu_op_o(apu_op), .apu_flags_o(apu_dflags),
        .apu_rvalid_i(apu_rvalid), .apu_result_i(apu_result), .apu_flags_i(apu_uflags),
        .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
        .wb_result_o(wb_result), .wb_flags_o(wb_flags), .wb_rd_o(wb_rd),
        .wb_err_o(wb_err), .busy_o(busy)
    );

    typedef struct {
        logic [WOP-1:0]      op;
        logic [NARGS*32-1:0] opnds;
        logic [NDS-1:0]      dflags;
        logic [4:0]          rd;
        int                  gnt_delay;
        int                  rv_at;      // WAIT cycle carrying rvalid, 0 = never
        logic [31:0]         rv_result;
        logic [NUS-1:0]      rv_flags;
        int                  wb_stall;
        bit                  spurious;
        logic [31:0]         exp_result;
        logic [NUS-1:0]      exp_flags;
        bit                  exp_err;
        int                  exp_wait;
    } vec_t;

    typedef struct {
        logic [31:0]    result;
        logic [NUS-1:0] flags;
        logic [4:0]     rd;
        bit             err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        cmd_valid  = 1'b0;
        apu_gnt    = 1'b0;
        apu_rvalid = 1'b0;
        apu_result = '0;
        apu_uflags = '0;
        wb_ready   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " ctrl"}, {cmd_ready, apu_req, wb_valid, wb_err, busy}, 0);
        chk({tag, " apu_data"}, {apu_op, apu_dflags}, 0);
        chk({tag, " apu_operands"}, apu_operands, 0);
        chk({tag, " wb_data"}, {wb_result, wb_flags, wb_rd}, 0);
    endtask

    function automatic vec_t mk(input logic [WOP-1:0] op, input logic [95:0] opnds,
                                input logic [NDS-1:0] df, input logic [4:0] rd,
                                input int gd, input int rv, input logic [31:0] rr,
                                input logic [NUS-1:0] rf, input int st, input bit sp,
                                input logic [31:0] er, input logic [NUS-1:0] ef,
                                input bit ee, input int ew);
        vec_t v;
        v.op = op; v.opnds = opnds; v.dflags = df; v.rd = rd;
        v.gnt_delay = gd; v.rv_at = rv; v.rv_result = rr; v.rv_flags = rf;
        v.wb_stall = st; v.spurious = sp;
        v.exp_result = er; v.exp_flags = ef; v.exp_err = ee; v.exp_wait = ew;
        return v;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int   n;
        exp_t e;
        exp_t got;
        n = 0;
        while (!cmd_ready && n < 20) begin tick; n++; end
        chk({tag, " cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_operands = v.opnds; cmd_op = v.op;
        cmd_flags = v.dflags; cmd_rd = v.rd;
        e.result = v.exp_result; e.flags = v.exp_flags; e.rd = v.rd; e.err = v.exp_err;
        sb.push_back(e);
        tick;
        cmd_valid = 1'b0; cmd_operands = ~v.opnds; cmd_op = ~v.op;
        cmd_flags = ~v.dflags; cmd_rd = ~v.rd;
        for (int k = 0; k <= v.gnt_delay; k++) begin
            chk({tag, " req"}, apu_req, 1);
            chk({tag, " req operands"}, apu_operands, v.opnds);
            chk({tag, " req op/flags"}, {apu_op, apu_dflags}, {v.op, v.dflags});
            chk({tag, " ready in req"}, {cmd_ready, busy}, 2'b01);
            apu_gnt    = (k == v.gnt_delay);
            apu_rvalid = v.spurious;
            apu_result = 32'h1234;
            tick;
            idle_inputs;
        end
        n = 0;
        while (!wb_valid && n < 40) begin
            n++;
            chk({tag, " req in wait"}, apu_req, 0);
            apu_rvalid = (n == v.rv_at);
            apu_result = v.rv_result;
            apu_uflags = v.rv_flags;
            tick;
            idle_inputs;
        end
        chk({tag, " wait cycles"}, n, v.exp_wait);
        chk({tag, " wb_valid"}, wb_valid, 1);
        if (!wb_valid) return;
        if (sb.size() == 0) begin
            chk({tag, " scoreboard empty"}, 0, 1);
            return;
        end
        got = sb.pop_front();
        for (int s = 0; s <= v.wb_stall; s++) begin
            chk({tag, " wb_valid held"}, wb_valid, 1);
            chk({tag, " wb_result"}, wb_result, got.result);
            chk({tag, " wb_flags/rd/err"}, {wb_flags, wb_rd, wb_err}, {got.flags, got.rd, got.err});
            chk({tag, " ready in wb"}, cmd_ready, 0);
            wb_ready   = (s == v.wb_stall);
            apu_rvalid = v.spurious && (s < v.wb_stall);
            apu_result = 32'h1234;
            apu_gnt    = v.spurious;
            tick;
            idle_inputs;
        end
        chk({tag, " retired"}, {wb_valid, cmd_ready, busy}, 3'b010);
    endtask

    task automatic back_to_back;
        int          cyc, accepted, retired, last_acc;
        bit          granted;
        logic [31:0] saved;
        exp_t        e, got;
        cyc = 0; accepted = 0; retired = 0; last_acc = -1; granted = 1'b0; saved = '0;
        wb_ready = 1'b1;
        while (retired < 10 && cyc < 200) begin
            if (wb_valid) begin
                if (sb.size() == 0) begin
                    chk("b2b scoreboard empty", 0, 1);
                end else begin
                    got = sb.pop_front();
                    chk("b2b result", wb_result, got.result);
                    chk("b2b rd/err", {wb_rd, wb_err}, {got.rd, got.err});
                end
                retired++;
            end
            cmd_valid = 1'b0;
            if (cmd_ready && accepted < 10) begin
                cmd_operands = {32'h3000_0000 + accepted, 32'h2000_0000 + accepted,
                                32'h0100_0000 * (accepted + 1) + 32'h77};
                cmd_op = WOP'(accepted + 2);
                cmd_flags = NDS'(accepted);
                cmd_rd = 5'(accepted + 10);
                e.result = (32'h0100_0000 * (accepted + 1) + 32'h77) ^ 32'h5A5A_0000;
                e.flags = '0; e.rd = 5'(accepted + 10); e.err = 1'b0;
                sb.push_back(e);
                if (last_acc >= 0) chk("b2b accept spacing", cyc - last_acc, 4);
                last_acc = cyc;
                accepted++;
                cmd_valid = 1'b1;
            end
            // Dummy responder: grant on request, respond the following cycle.
            apu_gnt    = apu_req;
            apu_rvalid = granted;
            apu_result = saved ^ 32'h5A5A_0000;
            apu_uflags = '0;
            if (apu_req) saved = apu_operands[31:0];
            granted = apu_req;
            tick;
            cyc++;
        end
        chk("b2b completions", retired, 10);
        chk("b2b scoreboard drained", sb.size(), 0);
        idle_inputs;
    endtask

    initial begin
        vecs[0] = mk(6'd1, {32'h33, 32'h22, 32'h11}, 15'h0005, 5'd7, 0, 1, 32'hDEAD_BEEF, 5'h03,
                     0, 1'b0, 32'hDEAD_BEEF, 5'h03, 1'b0, 1);
        vecs[1] = mk(6'd9, {32'hAAAA_0003, 32'h5555_0002, 32'hF0F0_0001}, 15'h7FFF, 5'd3, 5, 2,
                     32'hCAFE_0001, 5'h1F, 0, 1'b1, 32'hCAFE_0001, 5'h1F, 1'b0, 2);
        vecs[2] = mk(6'd2, {32'h1, 32'h2, 32'h3}, 15'h0100, 5'd12, 0, 0, 32'hFFFF_FFFF, 5'h1F,
                     0, 1'b0, 32'h0, 5'h00, 1'b1, 4);
        vecs[3] = mk(6'd3, {32'h4, 32'h5, 32'h6}, 15'h0200, 5'd13, 1, 4, 32'hA5A5_5A5A, 5'h0A,
                     0, 1'b0, 32'hA5A5_5A5A, 5'h0A, 1'b0, 4);
        vecs[4] = mk(6'd4, {32'h7, 32'h8, 32'h9}, 15'h0400, 5'd21, 0, 1, 32'h0BAD_F00D, 5'h15,
                     3, 1'b1, 32'h0BAD_F00D, 5'h15, 1'b0, 1);
        vecs[5] = mk(6'd63, {32'hFFFF_FFFF, 32'h0, 32'h8000_0000}, 15'h4000, 5'd31, 2, 3,
                     32'h0000_0001, 5'h10, 1, 1'b0, 32'h0000_0001, 5'h10, 1'b0, 3);

        rst = 1'b1;
        idle_inputs;
        cmd_operands = '0; cmd_op = '0; cmd_flags = '0; cmd_rd = '0;
        #1;
        check_all_zero("reset t0");
        tick; tick;
        check_all_zero("reset held");
        rst = 1'b0;
        #1;
        chk("post-reset ctrl", {cmd_ready, busy, apu_req, wb_valid}, 4'b1000);

        for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset while waiting for a response; the late response must be dropped.
        cmd_valid = 1'b1; cmd_operands = vecs[0].opnds; cmd_op = vecs[0].op;
        cmd_flags = vecs[0].dflags; cmd_rd = vecs[0].rd;
        tick;
        cmd_valid = 1'b0; apu_gnt = 1'b1;
        tick;
        apu_gnt = 1'b0;
        chk("midwait state", {busy, apu_req, wb_valid}, 3'b100);
        rst = 1'b1;
        #1;
        check_all_zero("midwait reset");
        tick;
        rst = 1'b0; apu_rvalid = 1'b1; apu_result = 32'h1234; apu_uflags = 5'h1F;
        #1;
        chk("after midwait reset", {cmd_ready, busy, wb_valid}, 3'b100);
        tick;
        idle_inputs;
        for (int i = 0; i < 3; i++) begin
            chk("late rvalid ignored", {wb_valid, busy}, 2'b00);
            tick;
        end
        run_txn(vecs[0], "post-reset txn");

        back_to_back;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
